// File: rtl/riscv_v_pkg.sv
// Shared types and default sizes for the vector pipeline controller.
package riscv_v_pkg;

  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_CNT_W      = 16;

  typedef logic [DEF_NUM_STAGES-1:0] stage_mask_t;

endpackage

// File: rtl/riscv_v_pipe_ctrl_slot.sv
// One stage of the valid/ready chain: holds the stage valid bit and derives load/move.
module riscv_v_pipe_ctrl_slot
  import riscv_v_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic up_move,
  input  logic nxt_rdy,
  input  logic busy,
  input  logic flush,
  input  logic mask,
  output logic load,
  output logic move,
  output logic valid,
  output logic stage_flush
);

  // A flush cycle freezes all movement; only masked stages are invalidated.
  assign move        = ~flush & valid & ~busy & nxt_rdy;
  assign load        = ~flush & (~valid | move);
  assign stage_flush = flush & mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (stage_flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= up_move;
    end
  end

endmodule

// File: rtl/riscv_v_pipe_ctrl.sv
// Valid/ready sequencer for a linear chain of stage registers, with masked flush and stall statistics.
module riscv_v_pipe_ctrl
  import riscv_v_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic [NUM_STAGES-1:0]           stage_busy,
  input  logic                            flush,
  input  logic [NUM_STAGES-1:0]           flush_mask,
  output logic [NUM_STAGES-1:0]           stage_en,
  output logic [NUM_STAGES-1:0]           stage_flush,
  output logic [NUM_STAGES-1:0]           stage_valid,
  output logic [$clog2(NUM_STAGES+1)-1:0] occupancy,
  output logic [CNT_W-1:0]                stall_cnt,
  input  logic                            stall_cnt_clr
);

  localparam int OCC_W = $clog2(NUM_STAGES+1);

  function automatic logic [OCC_W-1:0] popcount(input logic [NUM_STAGES-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      n = n + OCC_W'(v[k]);
    end
    return n;
  endfunction

  logic stall_inc;

  // Per-stage signals live in separate generate scopes so the ready chain is not one self-dependent vector.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic nxt_rdy_l;
    logic up_move_l;
    logic load_l;
    logic move_l;
    logic valid_l;
    logic flush_l;

    if (i == NUM_STAGES-1) begin : g_last
      assign nxt_rdy_l = out_ready;
    end else begin : g_mid
      assign nxt_rdy_l = g_stage[i+1].load_l;
    end

    if (i == 0) begin : g_first
      assign up_move_l = in_valid & load_l;
    end else begin : g_rest
      assign up_move_l = g_stage[i-1].move_l;
    end

    riscv_v_pipe_ctrl_slot u_slot (
      .clk         (clk),
      .rst         (rst),
      .up_move     (up_move_l),
      .nxt_rdy     (nxt_rdy_l),
      .busy        (stage_busy[i]),
      .flush       (flush),
      .mask        (flush_mask[i]),
      .load        (load_l),
      .move        (move_l),
      .valid       (valid_l),
      .stage_flush (flush_l)
    );

    assign stage_en[i]    = ~rst & load_l;
    assign stage_flush[i] = ~rst & flush_l;
    assign stage_valid[i] = valid_l;
  end

  assign in_ready  = ~rst & g_stage[0].load_l;
  assign out_valid = ~rst & ~flush & stage_valid[NUM_STAGES-1] & ~stage_busy[NUM_STAGES-1];
  assign occupancy = popcount(stage_valid);

  // Output stall: the oldest item is present but cannot leave this cycle.
  assign stall_inc = stage_valid[NUM_STAGES-1] & ~flush &
                     (~out_ready | stage_busy[NUM_STAGES-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_riscv_v_pipe_ctrl.sv
// Directed testbench for riscv_v_pipe_ctrl with NUM_STAGES=4.
module tb_riscv_v_pipe_ctrl;
  import riscv_v_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  stage_mask_t stage_busy;
  logic        flush;
  stage_mask_t flush_mask;
  stage_mask_t stage_en;
  stage_mask_t stage_flush;
  stage_mask_t stage_valid;
  logic [2:0]  occupancy;
  logic [15:0] stall_cnt;
  logic        stall_cnt_clr;

  int checks = 0;
  int errors = 0;
  int acc = 0;
  int del = 0;
  int acc_snap;
  int del_snap;

  riscv_v_pipe_ctrl #(.NUM_STAGES(4), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .stage_busy    (stage_busy),
    .flush         (flush),
    .flush_mask    (flush_mask),
    .stage_en      (stage_en),
    .stage_flush   (stage_flush),
    .stage_valid   (stage_valid),
    .occupancy     (occupancy),
    .stall_cnt     (stall_cnt),
    .stall_cnt_clr (stall_cnt_clr)
  );

  always #5 clk = ~clk;

  // Handshake counters sampled at the active edge (pre-update values).
  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) del++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stage_busy = '0;
    flush = 1'b0; flush_mask = '0; stall_cnt_clr = 1'b0;
    #2;
    chk("rst_valid", stage_valid, 4'b0000);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stage_en", stage_en, 4'b0000);
    chk("rst_occ", occupancy, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // Streaming
    cyc();
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("s1_c0_en", stage_en, 4'b1111);
    cyc(); #1; chk("s1_c1_valid", stage_valid, 4'b0001);
    cyc(); #1; chk("s1_c2_valid", stage_valid, 4'b0011);
    cyc(); #1; chk("s1_c3_valid", stage_valid, 4'b0111);
    chk("s1_c3_out_valid", out_valid, 0);
    cyc(); #1;
    chk("s1_c4_out_valid", out_valid, 1);
    chk("s1_c4_occ", occupancy, 4);
    chk("s1_c4_in_ready", in_ready, 1);
    chk("s1_c4_en", stage_en, 4'b1111);
    cyc(); #1;
    chk("s1_c5_out_valid", out_valid, 1);
    chk("s1_c5_occ", occupancy, 4);
    chk("s1_c5_stall", stall_cnt, 0);

    // Back-pressure for 3 cycles
    cyc();
    out_ready = 1'b0;
    #1;
    chk("s2_en", stage_en, 4'b0000);
    chk("s2_in_ready", in_ready, 0);
    chk("s2_out_valid", out_valid, 1);
    cyc(); #1; chk("s2_en_b", stage_en, 4'b0000);
    cyc(); #1; chk("s2_in_ready_c", in_ready, 0);
    cyc();
    out_ready = 1'b1;
    #1;
    chk("s2_stall3", stall_cnt, 3);
    chk("s2_resume_in_ready", in_ready, 1);
    chk("s2_resume_en", stage_en, 4'b1111);

    // Busy middle stage for 2 cycles
    cyc();
    stage_busy = 4'b0010;
    #1;
    chk("s3_b0_occ", occupancy, 4);
    chk("s3_b0_en", stage_en, 4'b1100);
    chk("s3_b0_in_ready", in_ready, 0);
    cyc(); #1;
    chk("s3_b1_valid", stage_valid, 4'b1011);
    chk("s3_b1_occ", occupancy, 3);
    chk("s3_b1_en", stage_en, 4'b1100);
    cyc();
    stage_busy = 4'b0000;
    #1;
    chk("s3_r0_valid", stage_valid, 4'b0011);
    chk("s3_r0_occ", occupancy, 2);
    chk("s3_r0_en", stage_en, 4'b1111);
    chk("s3_r0_conserve", acc - del, occupancy);
    cyc(); #1;
    chk("s3_r1_valid", stage_valid, 4'b0111);
    chk("s3_r1_out_valid", out_valid, 0);
    cyc(); #1;
    chk("s3_r2_valid", stage_valid, 4'b1111);
    chk("s3_r2_conserve", acc - del, 4);
    chk("s3_stall_kept", stall_cnt, 3);

    // Masked flush with in_valid and out_ready both high
    cyc();
    flush = 1'b1; flush_mask = 4'b0011;
    acc_snap = acc; del_snap = del;
    #1;
    chk("s4_stage_flush", stage_flush, 4'b0011);
    chk("s4_en", stage_en, 4'b0000);
    chk("s4_in_ready", in_ready, 0);
    chk("s4_out_valid", out_valid, 0);
    cyc();
    flush = 1'b0; flush_mask = 4'b0000;
    #1;
    chk("s4_valid_after", stage_valid, 4'b1100);
    chk("s5_no_accept", acc, acc_snap);
    chk("s5_no_consume", del, del_snap);
    chk("s4_stall_no_inc", stall_cnt, 3);
    chk("s4_flush_clear", stage_flush, 4'b0000);
    chk("s4_refill_en", stage_en, 4'b1111);
    chk("s4_refill_in_ready", in_ready, 1);
    cyc(); #1;
    chk("s4_refilled", stage_valid, 4'b1001);

    // Freeze: flush with empty mask
    flush = 1'b1;
    #1;
    chk("frz_en", stage_en, 4'b0000);
    chk("frz_stage_flush", stage_flush, 4'b0000);
    cyc();
    flush = 1'b0;
    #1;
    chk("frz_hold", stage_valid, 4'b1001);

    // Stall counter clear priority, then increments
    out_ready = 1'b0; stall_cnt_clr = 1'b1;
    cyc();
    stall_cnt_clr = 1'b0;
    #1;
    chk("clr_stall", stall_cnt, 0);
    chk("clr_valid", stage_valid, 4'b1011);
    cyc();
    out_ready = 1'b1; stage_busy = 4'b1000;
    #1;
    chk("stall_inc1", stall_cnt, 1);
    chk("busy_last_out_valid", out_valid, 0);
    cyc(); #1;
    chk("stall_inc_busy", stall_cnt, 2);
    chk("pre_rst_valid", stage_valid, 4'b1111);

    // Asynchronous reset mid-cycle
    stage_busy = 4'b0000;
    #2;
    rst = 1'b1; flush = 1'b1; flush_mask = 4'b1111;
    #1;
    chk("arst_valid", stage_valid, 4'b0000);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_en", stage_en, 4'b0000);
    chk("arst_flush", stage_flush, 4'b0000);
    cyc();
    rst = 1'b0; flush = 1'b0; flush_mask = 4'b0000;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_valid", stage_valid, 4'b0000);
    cyc(); #1;
    chk("post_rst_accept", stage_valid, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_v_pipe_ctrl.md
Name: riscv_v_pipe_ctrl

Overview:
Valid/ready sequencer for a linear chain of NUM_STAGES pipeline stage registers in the vector datapath. Each stage register has en and flush inputs.
- Tracks one valid bit per stage.
- Drives each stage's en and flush.
- Propagates back-pressure from the consumer and from per-stage busy (multi-cycle) conditions.
- Applies masked flushes on redirect or exception.
- Exposes occupancy and stall statistics for performance counters.

Parameters:
NUM_STAGES, 4, number of controlled stage registers (>=1); stage 0 is the oldest-input side, stage NUM_STAGES-1 feeds the consumer.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  producer has an item
in_ready  out  1  controller accepts the item this cycle
out_valid  out  1  stage NUM_STAGES-1 holds a completed item
out_ready  in  1  consumer accepts it
stage_busy  in  NUM_STAGES  stage i needs more cycles; its item must not move
flush  in  1  flush request
flush_mask  in  NUM_STAGES  stages to invalidate when flush=1
stage_en  out  NUM_STAGES  en for stage register i
stage_flush  out  NUM_STAGES  flush for stage register i
stage_valid  out  NUM_STAGES  registered valid bits
occupancy  out  $clog2(NUM_STAGES+1)  popcount(stage_valid)
stall_cnt  out  CNT_W  saturating count of output-stall cycles
stall_cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset (async, rst=1):
  - valid[*]=0, stall_cnt=0.
  - Combinational outputs are forced while rst=1: in_ready=0, out_valid=0, stage_en=0, stage_flush=0.
- Definitions (no flush):
  - move[i] = valid[i] & ~stage_busy[i] & nxt_rdy[i], where nxt_rdy[N-1]=out_ready and nxt_rdy[i]=load[i+1].
  - load[i] = ~valid[i] | move[i].
  - in_ready = load[0].
  - out_valid = valid[N-1] & ~stage_busy[N-1].
  - stage_en[i] = load[i]. A bubble load is permitted; its data is don't-care.
- Valid update when load[i]=1:
  - valid[0] <= in_valid & in_ready.
  - valid[i] <= move[i-1] for i>0.
  - When load[i]=0, valid[i] holds.
- Ready chain: combinational from out_ready back to in_ready. A full pipe with out_ready=1 and no busy stages sustains 1 item/cycle.
- Latency: an item accepted in cycle t is visible on out_valid in cycle t+NUM_STAGES when there are no stalls.
- Flush cycle (flush=1) takes priority over all movement:
  - stage_en=0, in_ready=0, out_valid=0.
  - stage_flush[i]=flush_mask[i]; masked stages get valid<=0.
  - Unmasked stages hold their valid and data.
  - flush with flush_mask=0 is a one-cycle freeze.
- Busy stage i: holds its item. Upstream stages fill bubbles up to stage i and then stall. Downstream stages drain.
- stall_cnt:
  - Increments when valid[N-1]=1, flush=0 and the item does not leave (~out_ready | stage_busy[N-1]).
  - Saturates at all-ones.
  - stall_cnt_clr has priority over increment.
- occupancy is combinational from the registered valid bits.
- Reset mid-operation: all in-flight items are dropped immediately. No stage_flush pulse is generated.

Decomposition:
- Package riscv_v_pkg:
  - stage_mask_t (NUM_STAGES-bit vector type helper).
  - Default CNT_W constant.
- Sub-module riscv_v_pipe_ctrl_slot, one per stage:
  - Holds the valid bit.
  - Inputs: upstream move, nxt_rdy, busy, flush, mask bit.
  - Outputs: load, move, valid, flush.
- Top level: generate-instantiates the slots, the ready chain, popcount and stall counter.

Test Plan:
(All scenarios use NUM_STAGES=4.)
1. Streaming: in_valid=1 and out_ready=1 from cycle 0 with items A,B,C... -> out_valid first high in cycle 4 (A), then one item per cycle; occupancy=4 in steady state; stall_cnt=0.
2. Back-pressure: fill the pipe, then drop out_ready for 3 cycles -> stage_en=0000, in_ready=0, stall_cnt=3; after out_ready=1, in_ready=1 in that same cycle.
3. Busy middle stage: stage_busy[1]=1 for 2 cycles with a full pipe and out_ready=1 -> stages 2,3 drain, occupancy 4->3->2, stage_en[0]=stage_en[1]=0; resume with no lost or duplicated items.
4. Masked flush: full pipe, flush=1, flush_mask=0011 -> stage_flush=0011, stage_valid becomes 1100, in_ready=0 and out_valid=0 that cycle; next cycle stages 0,1 refill.
5. Flush coinciding with out_ready=1 and in_valid=1 -> no item consumed, no item accepted; flush has priority.
6. Async reset asserted mid-stream between clock edges -> stage_valid=0000 and stall_cnt=0 immediately; in_ready=0 while rst=1, and in_ready=1 in the first cycle after release.
